// File: rtl/count_capture.sv
// Capture stage for an asynchronous 4-bit ripple counter: synchroniser, stability filter,
// wrap extension, threshold match and a valid/ready snapshot port. Option: SNAP_DROP_EN.
module count_capture #(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned EXT    = 4,
  parameter int unsigned STABLE = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [WIDTH-1:0]     count_i,
  input  logic [WIDTH+EXT-1:0] thresh_i,
  input  logic                 snap_req_i,
  input  logic                 snap_ready_i,
  output logic                 snap_valid_o,
  output logic [WIDTH+EXT-1:0] snap_data_o,
  output logic [WIDTH+EXT-1:0] count_ext_o,
  output logic                 wrap_o,
`ifdef SNAP_DROP_EN
  output logic                 snap_drop_o,
`endif
  output logic                 match_o
);

  localparam int unsigned RunW = $clog2(STABLE + 1);
  localparam int unsigned OutW = WIDTH + EXT;

  logic [WIDTH-1:0] s1_q, s2_q;
  logic [RunW-1:0]  run_q, run_d;
  logic [WIDTH-1:0] filt_q, filt_d;
  logic [EXT-1:0]   hi_q, hi_d;
  logic             wrap_q, wrap_d;
  logic             match_q, match_d;
  logic             snap_valid_q, snap_valid_d;
  logic [OutW-1:0]  snap_data_q, snap_data_d;
  logic             update;

  // A value is accepted once it has been seen STABLE times in a row and differs from filt.
  always_comb begin
    run_d = run_q;
    if (s1_q != s2_q) begin
      run_d = RunW'(1);
    end else if (run_q != RunW'(STABLE)) begin
      run_d = run_q + RunW'(1);
    end
  end

  assign update = (run_q == RunW'(STABLE)) && (s2_q != filt_q);

  always_comb begin
    filt_d  = filt_q;
    hi_d    = hi_q;
    wrap_d  = 1'b0;
    match_d = 1'b0;
    if (update) begin
      filt_d = s2_q;
      if (s2_q < filt_q) begin
        hi_d   = hi_q + EXT'(1);
        wrap_d = 1'b1;
      end
      match_d = ({hi_d, s2_q} == thresh_i);
    end
  end

  // Recapture is allowed on the completing edge; otherwise a request while full is dropped.
  always_comb begin
    snap_valid_d = snap_valid_q;
    snap_data_d  = snap_data_q;
    if (snap_req_i && (!snap_valid_q || snap_ready_i)) begin
      snap_valid_d = 1'b1;
      snap_data_d  = {hi_q, filt_q};
    end else if (snap_valid_q && snap_ready_i) begin
      snap_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_q         <= '0;
      s2_q         <= '0;
      run_q        <= '0;
      filt_q       <= '0;
      hi_q         <= '0;
      wrap_q       <= 1'b0;
      match_q      <= 1'b0;
      snap_valid_q <= 1'b0;
      snap_data_q  <= '0;
    end else begin
      s1_q         <= count_i;
      s2_q         <= s1_q;
      run_q        <= run_d;
      filt_q       <= filt_d;
      hi_q         <= hi_d;
      wrap_q       <= wrap_d;
      match_q      <= match_d;
      snap_valid_q <= snap_valid_d;
      snap_data_q  <= snap_data_d;
    end
  end

`ifdef SNAP_DROP_EN
  logic snap_drop_q, snap_drop_d;

  always_comb begin
    snap_drop_d = snap_drop_q;
    if (snap_valid_q && snap_ready_i) begin
      snap_drop_d = 1'b0;
    end else if (snap_req_i && snap_valid_q) begin
      snap_drop_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      snap_drop_q <= 1'b0;
    end else begin
      snap_drop_q <= snap_drop_d;
    end
  end

  assign snap_drop_o = snap_drop_q;
`endif

  assign count_ext_o  = {hi_q, filt_q};
  assign wrap_o       = wrap_q;
  assign match_o      = match_q;
  assign snap_valid_o = snap_valid_q;
  assign snap_data_o  = snap_data_q;

endmodule
